store_unit_ctrl: RTL and testbench

- Store sequencer between the execute stage and the data-memory write port.
- Accepts one store at a time: raw rs2 data, byte address and store size (SW/SH/SB).
- Shifts the data onto the correct byte lanes and generates byte enables.
- Issues word-aligned write beats over a req/gnt handshake. A store that crosses a word boundary is split into two beats.
- Reports completion or error to the pipeline with single-cycle pulses.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/store_unit_ctrl_if.sv | 26 ++
 rtl/store_lane_align.sv | 30 +++
 rtl/store_unit_ctrl.sv | 104 ++++++++++
 tb/tb_store_unit_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the store sequencer: size encodings,
// FSM states and per-size byte-enable patterns.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } store_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LO   = 2'b01,
    HI   = 2'b10,
    ERR  = 2'b11
  } st_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Bytes are never misaligned; halves need an even offset, words offset 0.
  function automatic logic is_misaligned(input store_size_e size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/store_unit_ctrl_if.sv
// Store request from the pipeline and write-beat port towards data memory.
// The controller takes the slave view; pipeline plus memory take the master view.
interface store_unit_ctrl_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        st_err;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_gnt,
    input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_gnt,
    output st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_lane_align.sv
// Moves store data onto its byte lanes across a two-word window and builds
// the matching 8-bit byte mask; upper half belongs to the following word.
module store_lane_align
  import lsu_pkg::*;
(
  input  store_size_e  size,
  input  logic [1:0]   off,
  input  logic [31:0]  data,
  output logic [7:0]   mask,
  output logic [63:0]  sdata
);

  logic [3:0]  m;
  logic [31:0] dm;

  always_comb begin
    m  = 4'b0000;
    dm = 32'h0;
    case (size)
      SZ_WORD: begin m = BE_WORD; dm = data;                 end
      SZ_HALF: begin m = BE_HALF; dm = {16'h0, data[15:0]};  end
      SZ_BYTE: begin m = BE_BYTE; dm = {24'h0, data[7:0]};   end
      default: begin m = 4'b0000; dm = 32'h0;                end
    endcase
  end

  assign mask  = {4'b0000, m} << off;
  assign sdata = {32'h0, dm} << {off, 3'b000};

endmodule

// File: rtl/store_unit_ctrl.sv
// Store sequencer: latches one store, issues one or two word-aligned write
// beats over req/gnt and reports completion or rejection with pulses.
//
// state | meaning
// IDLE  | ready for a new store, no bus activity
// LO    | low (or only) beat requested, waiting for gnt
// HI    | second beat of a word-crossing store, waiting for gnt
// ERR   | one-cycle st_err pulse for a rejected store
module store_unit_ctrl
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  store_unit_ctrl_if.slave  bus
);

  st_state_e   state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  store_size_e size_q;

  logic [7:0]  mask;
  logic [63:0] sdata;
  logic [31:0] lo_addr;
  logic        split;
  store_size_e in_size;

  assign in_size = store_size_e'(bus.st_size);

  store_lane_align u_align (
    .size  (size_q),
    .off   (addr_q[1:0]),
    .data  (data_q),
    .mask  (mask),
    .sdata (sdata)
  );

  assign lo_addr = {addr_q[31:2], 2'b00};
  assign split   = (mask[7:4] != 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= 32'h0;
      data_q <= 32'h0;
      size_q <= SZ_WORD;
    end else begin
      case (state)
        IDLE: begin
          if (bus.st_valid) begin
            addr_q <= bus.st_addr;
            data_q <= bus.st_data;
            size_q <= in_size;
            if ((in_size == SZ_ILL) ||
                (!ALLOW_MISALIGNED && is_misaligned(in_size, bus.st_addr[1:0])))
              state <= ERR;
            else
              state <= LO;
          end
        end
        LO:      if (bus.mem_gnt) state <= split ? HI : IDLE;
        HI:      if (bus.mem_gnt) state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state and latched operands only, so the beat
  // stays stable until granted; rst forces them quiet immediately.
  always_comb begin
    bus.st_ready  = 1'b0;
    bus.st_err    = 1'b0;
    bus.st_done   = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_be    = 4'b0000;
    if (!rst) begin
      case (state)
        IDLE: bus.st_ready = 1'b1;
        LO: begin
          bus.mem_req   = 1'b1;
          bus.mem_addr  = lo_addr;
          bus.mem_be    = mask[3:0];
          bus.mem_wdata = sdata[31:0];
          bus.st_done   = bus.mem_gnt && !split;
        end
        HI: begin
          bus.mem_req   = 1'b1;
          bus.mem_addr  = lo_addr + 32'd4;
          bus.mem_be    = mask[7:4];
          bus.mem_wdata = sdata[63:32];
          bus.st_done   = bus.mem_gnt;
        end
        ERR:     bus.st_err = 1'b1;
        default: bus.st_ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit_ctrl.sv
// Directed bench for store_unit_ctrl: aligned, sub-word, split, stalled,
// wrapping, illegal, misaligned-reject and reset-mid-store vectors.
module tb_store_unit_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  store_unit_ctrl_if bus ();
  store_unit_ctrl_if bus_na ();

  store_unit_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  store_unit_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk (clk),
    .rst (rst),
    .bus (bus_na.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.st_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_store", 32'(bus.st_ready), 32'd1);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = s;
    @(negedge clk);
    bus.st_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ew,
                      input logic edone, input int nwait);
    for (int i = 0; i < nwait; i++) begin
      bus.mem_gnt = 1'b0;
      #1;
      chk("wait_req",   32'(bus.mem_req),   32'd1);
      chk("wait_addr",  bus.mem_addr,       ea);
      chk("wait_be",    32'(bus.mem_be),    32'(ebe));
      chk("wait_wdata", bus.mem_wdata,      ew);
      chk("wait_done",  32'(bus.st_done),   32'd0);
      @(negedge clk);
    end
    bus.mem_gnt = 1'b1;
    #1;
    chk("beat_req",   32'(bus.mem_req), 32'd1);
    chk("beat_addr",  bus.mem_addr,     ea);
    chk("beat_be",    32'(bus.mem_be),  32'(ebe));
    chk("beat_wdata", bus.mem_wdata,    ew);
    chk("beat_done",  32'(bus.st_done), 32'(edone));
    @(negedge clk);
  endtask

  task automatic idle_check();
    #1;
    chk("idle_req",   32'(bus.mem_req),  32'd0);
    chk("idle_done",  32'(bus.st_done),  32'd0);
    chk("idle_ready", 32'(bus.st_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.st_valid = 1'b0;    bus.st_addr = 32'h0;    bus.st_data = 32'h0;
    bus.st_size = 2'b00;    bus.mem_gnt = 1'b1;
    bus_na.st_valid = 1'b0; bus_na.st_addr = 32'h0; bus_na.st_data = 32'h0;
    bus_na.st_size = 2'b00; bus_na.mem_gnt = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.st_ready),  32'd0);
    chk("rst_req",   32'(bus.mem_req),   32'd0);
    chk("rst_addr",  bus.mem_addr,       32'h0);
    chk("rst_wdata", bus.mem_wdata,      32'h0);
    chk("rst_be",    32'(bus.mem_be),    32'd0);
    chk("rst_done",  32'(bus.st_done),   32'd0);
    chk("rst_err",   32'(bus.st_err),    32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.st_ready), 32'd1);

    // SW aligned
    start_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b00);
    beat(32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b1, 0);
    idle_check();

    // SB top lane, no second beat
    start_store(32'h0000_0203, 32'h1234_56AB, 2'b10);
    beat(32'h0000_0200, 4'b1000, 32'hAB00_0000, 1'b1, 0);
    idle_check();

    // SH crossing a word boundary
    start_store(32'h0000_0107, 32'h0000_CAFE, 2'b01);
    beat(32'h0000_0104, 4'b1000, 32'hFE00_0000, 1'b0, 0);
    beat(32'h0000_0108, 4'b0001, 32'h0000_00CA, 1'b1, 0);
    idle_check();

    // SW split with three stall cycles per beat
    start_store(32'h0000_0102, 32'h1122_3344, 2'b00);
    beat(32'h0000_0100, 4'b1100, 32'h3344_0000, 1'b0, 3);
    beat(32'h0000_0104, 4'b0011, 32'h0000_1122, 1'b1, 3);
    idle_check();

    // SW wrapping past the top of the address space
    start_store(32'hFFFF_FFFE, 32'hA5A5_5A5A, 2'b00);
    beat(32'hFFFF_FFFC, 4'b1100, 32'h5A5A_0000, 1'b0, 0);
    beat(32'h0000_0000, 4'b0011, 32'h0000_A5A5, 1'b1, 0);
    idle_check();

    // Illegal size
    start_store(32'h0000_0300, 32'h0000_0001, 2'b11);
    #1;
    chk("ill_err",   32'(bus.st_err),   32'd1);
    chk("ill_req",   32'(bus.mem_req),  32'd0);
    chk("ill_ready", 32'(bus.st_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("ill_err_clear", 32'(bus.st_err),   32'd0);
    chk("ill_ready_ret", 32'(bus.st_ready), 32'd1);
    chk("ill_req_low",   32'(bus.mem_req),  32'd0);

    // Misaligned rejection on the strict instance
    bus_na.st_valid = 1'b1;
    bus_na.st_addr  = 32'h0000_0101;
    bus_na.st_data  = 32'h0000_BEEF;
    bus_na.st_size  = 2'b01;
    @(negedge clk);
    bus_na.st_valid = 1'b0;
    #1;
    chk("na_err",  32'(bus_na.st_err),  32'd1);
    chk("na_req",  32'(bus_na.mem_req), 32'd0);
    @(negedge clk);
    #1;
    chk("na_err_clear", 32'(bus_na.st_err),   32'd0);
    chk("na_ready",     32'(bus_na.st_ready), 32'd1);
    chk("na_req_low",   32'(bus_na.mem_req),  32'd0);

    // Strict instance still accepts an odd-address byte
    bus_na.st_valid = 1'b1;
    bus_na.st_addr  = 32'h0000_0101;
    bus_na.st_data  = 32'h0000_0077;
    bus_na.st_size  = 2'b10;
    @(negedge clk);
    bus_na.st_valid = 1'b0;
    #1;
    chk("na_sb_req",   32'(bus_na.mem_req), 32'd1);
    chk("na_sb_addr",  bus_na.mem_addr,     32'h0000_0100);
    chk("na_sb_be",    32'(bus_na.mem_be),  32'd2);
    chk("na_sb_wdata", bus_na.mem_wdata,    32'h0000_7700);
    chk("na_sb_done",  32'(bus_na.st_done), 32'd1);
    chk("na_sb_err",   32'(bus_na.st_err),  32'd0);
    @(negedge clk);
    #1;
    chk("na_sb_idle", 32'(bus_na.mem_req), 32'd0);

    // Reset while the high beat waits for gnt
    start_store(32'h0000_0107, 32'h0000_CAFE, 2'b01);
    beat(32'h0000_0104, 4'b1000, 32'hFE00_0000, 1'b0, 0);
    bus.mem_gnt = 1'b0;
    #1;
    chk("hi_wait_req",  32'(bus.mem_req), 32'd1);
    chk("hi_wait_addr", bus.mem_addr,     32'h0000_0108);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_req",   32'(bus.mem_req),  32'd0);
    chk("midrst_done",  32'(bus.st_done),  32'd0);
    chk("midrst_ready", 32'(bus.st_ready), 32'd0);
    chk("midrst_addr",  bus.mem_addr,      32'h0);
    rst = 1'b0;
    bus.mem_gnt = 1'b1;
    #1;
    chk("midrst_ready_rel", 32'(bus.st_ready), 32'd1);
    chk("midrst_req_rel",   32'(bus.mem_req),  32'd0);

    start_store(32'h0000_0400, 32'h0BAD_F00D, 2'b00);
    beat(32'h0000_0400, 4'b1111, 32'h0BAD_F00D, 1'b1, 0);
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
